// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the controller that fills and drains it.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ctrl_state_t;

    // The queue is exactly as deep as the register file addressed by address_t.
    localparam int DEPTH   = 2 ** $bits(address_t);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

endpackage

// File: rtl/instr_register_ctrl_if.sv
// Producer, consumer and instruction-register signals of instr_register_ctrl.
interface instr_register_ctrl_if #(
    parameter int N_REQ = 2
);
    import instr_register_pkg::*;

    logic [N_REQ-1:0]     req;
    opcode_t  [N_REQ-1:0] req_opcode;
    operand_t [N_REQ-1:0] req_operand_a;
    operand_t [N_REQ-1:0] req_operand_b;
    logic [N_REQ-1:0]     gnt;
    logic                 flush;
    logic                 rd_ready;
    logic                 rd_valid;
    logic [COUNT_W-1:0]   count;
    logic                 full;
    logic                 empty;
    logic                 load_en;
    opcode_t              opcode;
    operand_t             operand_a;
    operand_t             operand_b;
    address_t             write_pointer;
    address_t             read_pointer;

    modport slave (
        input  req, req_opcode, req_operand_a, req_operand_b, flush, rd_ready,
        output gnt, rd_valid, count, full, empty, load_en, opcode, operand_a,
               operand_b, write_pointer, read_pointer
    );

    modport master (
        output req, req_opcode, req_operand_a, req_operand_b, flush, rd_ready,
        input  gnt, rd_valid, count, full, empty, load_en, opcode, operand_a,
               operand_b, write_pointer, read_pointer
    );

endinterface

// File: rtl/instr_register_ctrl_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after rr_ptr wins (one-hot).
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         winner
);
    localparam int PW = $clog2(N_REQ);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N_REQ)) begin
                sum = sum - (PW + 1)'(N_REQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_register_ctrl.sv
// Arbitrates N_REQ producers into instr_register and runs it as a circular FIFO
// for a single valid/ready consumer.
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_register_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(N_REQ);

    ctrl_state_t        state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   winner_q, winner_d;
    logic               load_en_q, load_en_d;
    opcode_t            opcode_q, opcode_d;
    operand_t           operand_a_q, operand_a_d;
    operand_t           operand_b_q, operand_b_d;
    address_t           wp_q, wp_d;
    address_t           rp_q, rp_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   arb_winner;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   grant_idx;
    logic               space;
    logic               capture;
    logic               commit;
    logic               pop;

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) onehot_idx = PTR_W'(i);
        end
    endfunction

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (eligible),
        .rr_ptr (rr_ptr_q),
        .winner (arb_winner)
    );

    always_comb begin
        eligible    = bus.req;
        state_d     = IDLE;
        load_en_d   = 1'b0;
        winner_d    = winner_q;
        opcode_d    = opcode_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        rr_ptr_d    = rr_ptr_q;
        arb_idx     = onehot_idx(arb_winner);
        grant_idx   = onehot_idx(winner_q);

        // The requester being granted this cycle cannot win the next slot.
        case (state_q)
            IDLE:    eligible = bus.req;
            LOAD:    eligible = bus.req & ~winner_q;
            default: eligible = bus.req;
        endcase

        // An in-flight load already occupies a slot.
        space   = (count_q + COUNT_W'(load_en_q)) < COUNT_W'(DEPTH);
        capture = (|eligible) && space && !bus.flush;
        commit  = load_en_q && !bus.flush;
        pop     = (count_q != '0) && bus.rd_ready;

        if (load_en_q) begin
            rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end

        if (capture) begin
            state_d     = LOAD;
            load_en_d   = 1'b1;
            winner_d    = arb_winner;
            opcode_d    = bus.req_opcode[arb_idx];
            operand_a_d = bus.req_operand_a[arb_idx];
            operand_b_d = bus.req_operand_b[arb_idx];
        end

        if (bus.flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            wp_d    = wp_q + address_t'(commit);
            rp_d    = rp_q + address_t'(pop);
            count_d = count_q + COUNT_W'(commit) - COUNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            load_en_q   <= 1'b0;
            opcode_q    <= ZERO;
            operand_a_q <= '0;
            operand_b_q <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            load_en_q   <= load_en_d;
            opcode_q    <= opcode_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
        end
    end

    assign bus.gnt           = load_en_q ? winner_q : '0;
    assign bus.load_en       = load_en_q;
    assign bus.opcode        = opcode_q;
    assign bus.operand_a     = operand_a_q;
    assign bus.operand_b     = operand_b_q;
    assign bus.write_pointer = wp_q;
    assign bus.read_pointer  = rp_q;
    assign bus.count         = count_q;
    assign bus.rd_valid      = (count_q != '0);
    assign bus.empty         = (count_q == '0);
    assign bus.full          = (count_q == COUNT_W'(DEPTH));

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Directed bench for instr_register_ctrl with a behavioural instr_register array
// that holds every word written on load_en.
module tb_instr_register_ctrl;
    import instr_register_pkg::*;

    localparam int N_REQ = 2;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;
    int   gnt_seen;
    logic [7:0] wp_at_gnt;

    instruction_t mem [DEPTH];

    instr_register_ctrl_if #(.N_REQ(N_REQ)) bus ();

    instr_register_ctrl #(.N_REQ(N_REQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaviour of the instruction register itself: store whatever is loaded.
    always @(posedge clk) begin
        if (bus.load_en) begin
            mem[bus.write_pointer] <= {bus.opcode, bus.operand_a, bus.operand_b};
        end
    end

    function automatic instruction_t mkInstr(input opcode_t o, input operand_t a, input operand_t b);
        mkInstr = {o, a, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic flush, input logic rd_ready);
        bus.req      = req;
        bus.flush    = flush;
        bus.rd_ready = rd_ready;
    endtask

    task automatic setPayload(input int idx, input opcode_t o, input operand_t a, input operand_t b);
        bus.req_opcode[idx]    = o;
        bus.req_operand_a[idx] = a;
        bus.req_operand_b[idx] = b;
    endtask

    task automatic checkReset(input string p);
        checkOutput({p, "_gnt"},      bus.gnt, 0);
        checkOutput({p, "_load_en"},  bus.load_en, 0);
        checkOutput({p, "_count"},    bus.count, 0);
        checkOutput({p, "_empty"},    bus.empty, 1);
        checkOutput({p, "_full"},     bus.full, 0);
        checkOutput({p, "_rd_valid"}, bus.rd_valid, 0);
        checkOutput({p, "_wp"},       bus.write_pointer, 0);
        checkOutput({p, "_rp"},       bus.read_pointer, 0);
        checkOutput({p, "_opcode"},   bus.opcode, ZERO);
        checkOutput({p, "_op_a"},     bus.operand_a, 0);
        checkOutput({p, "_op_b"},     bus.operand_b, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0);
        setPayload(0, ZERO, 0, 0);
        setPayload(1, ZERO, 0, 0);
        #2 reset_n = 1'b0;
        #1 checkReset("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Single write from producer 0.
        setPayload(0, ADD, 5, 3);
        applyStimulus(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_gnt",     bus.gnt, 2'b01);
        checkOutput("t1_load_en", bus.load_en, 1);
        checkOutput("t1_wp",      bus.write_pointer, 0);
        checkOutput("t1_opcode",  bus.opcode, ADD);
        checkOutput("t1_op_a",    bus.operand_a, 5);
        checkOutput("t1_op_b",    bus.operand_b, 3);
        applyStimulus(2'b00, 1'b0, 1'b0);
        setPayload(0, SUB, 9, 9);
        @(negedge clk);
        checkOutput("t1_gnt_off",  bus.gnt, 0);
        checkOutput("t1_count",    bus.count, 1);
        checkOutput("t1_rd_valid", bus.rd_valid, 1);
        checkOutput("t1_empty",    bus.empty, 0);
        checkOutput("t1_word",     mem[bus.read_pointer], mkInstr(ADD, 5, 3));
        applyStimulus(2'b00, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t1_pop_count", bus.count, 0);
        checkOutput("t1_pop_rp",    bus.read_pointer, 1);
        checkOutput("t1_pop_empty", bus.empty, 1);

        // Contention: grants alternate with no gap cycles.
        doReset();
        setPayload(0, SUB, 10, 1);
        setPayload(1, MULT, 20, 2);
        applyStimulus(2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_gnt%0d", k),    bus.gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("t2_wp%0d", k),     bus.write_pointer, k);
            checkOutput($sformatf("t2_opcode%0d", k), bus.opcode, (k % 2 == 0) ? SUB : MULT);
        end
        applyStimulus(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t2_count",   bus.count, 4);
        checkOutput("t2_load_en", bus.load_en, 0);
        checkOutput("t2_word0",   mem[bus.read_pointer], mkInstr(SUB, 10, 1));
        checkOutput("t2_word1",   mem[1], mkInstr(MULT, 20, 2));

        // Fill to full with the consumer stalled, then free one slot.
        doReset();
        applyStimulus(2'b11, 1'b0, 1'b0);
        gnt_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.gnt != '0) gnt_seen++;
        end
        checkOutput("t3_gnts",  gnt_seen, 32);
        checkOutput("t3_full",  bus.full, 1);
        checkOutput("t3_count", bus.count, 32);
        checkOutput("t3_wp",    bus.write_pointer, 0);
        checkOutput("t3_gnt",   bus.gnt, 0);
        applyStimulus(2'b11, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(2'b11, 1'b0, 1'b0);
        checkOutput("t3_pop_count", bus.count, 31);
        checkOutput("t3_pop_full",  bus.full, 0);
        checkOutput("t3_pop_rp",    bus.read_pointer, 1);
        gnt_seen  = 0;
        wp_at_gnt = 8'hff;
        repeat (8) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                gnt_seen++;
                wp_at_gnt = 8'(bus.write_pointer);
            end
        end
        checkOutput("t3_refill_gnts", gnt_seen, 1);
        checkOutput("t3_refill_wp",   wp_at_gnt, 0);
        checkOutput("t3_refill_full", bus.full, 1);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Simultaneous commit and pop at count 5.
        doReset();
        setPayload(0, PASSB, 1, 2);
        setPayload(1, PASSB, 3, 4);
        applyStimulus(2'b11, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t4_count5", bus.count, 5);
        checkOutput("t4_wp5",    bus.write_pointer, 5);
        applyStimulus(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t4_gnt", bus.gnt, 2'b01);
        applyStimulus(2'b00, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t4_count", bus.count, 5);
        checkOutput("t4_wp",    bus.write_pointer, 6);
        checkOutput("t4_rp",    bus.read_pointer, 1);

        // Flush with a load in flight at count 7.
        applyStimulus(2'b11, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_count7", bus.count, 7);
        setPayload(0, DIV, 99, 77);
        applyStimulus(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_load_en", bus.load_en, 1);
        applyStimulus(2'b00, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t5_count",    bus.count, 0);
        checkOutput("t5_wp",       bus.write_pointer, 0);
        checkOutput("t5_rp",       bus.read_pointer, 0);
        checkOutput("t5_empty",    bus.empty, 1);
        checkOutput("t5_rd_valid", bus.rd_valid, 0);
        checkOutput("t5_load_off", bus.load_en, 0);
        setPayload(0, PASSA, 7, 8);
        applyStimulus(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_regnt",     bus.gnt, 2'b01);
        checkOutput("t5_still_inv", bus.rd_valid, 0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_new_count", bus.count, 1);
        checkOutput("t5_new_word",  mem[bus.read_pointer], mkInstr(PASSA, 7, 8));

        // Asynchronous reset in the middle of a LOAD cycle.
        setPayload(0, MOD, 4, 4);
        applyStimulus(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t6_pre_gnt", bus.gnt, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_async_load_en", bus.load_en, 0);
        checkOutput("t6_async_gnt",     bus.gnt, 0);
        @(negedge clk);
        checkReset("t6_rst");
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_regnt",  bus.gnt, 2'b01);
        checkOutput("t6_opcode", bus.opcode, MOD);
        checkOutput("t6_wp",     bus.write_pointer, 0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t6_count", bus.count, 1);
        checkOutput("t6_word",  mem[bus.read_pointer], mkInstr(MOD, 4, 4));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
